// File: rtl/serial_pkg.sv
// Shared types, widths and helpers for the four-requester serial frame transmitter.
package serial_pkg;

    localparam int   NREQ       = 4;
    localparam int   PORT_W     = 2;
    localparam int   CNT_W      = 4;
    localparam int   BYTE_W     = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        PORT,
        COUNT,
        DATA,
        GAP
    } state_e;

    function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: the search begins one past the previous winner and wraps 3 -> 0.
module rr_arbiter_4
    import serial_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    always_comb begin
        logic [1:0] idx;
        logic       found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = last + 2'(k);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Arbitrates four frame requesters and serialises start, port, count and payload bytes MSB first.
//   state | meaning
//   IDLE  | line high, arbitrate on req
//   START | start bit (0)
//   PORT  | 2 port bits
//   COUNT | 4 byte-count bits
//   DATA  | 8*N payload bits
//   GAP   | line high for GAP_CYCLES, grant held
module serial_tx_scheduler
    import serial_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*PORT_W-1:0] req_port,
    input  logic [NREQ*CNT_W-1:0]  req_bytes,
    input  logic [NREQ*BYTE_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        byte_ack,
    output logic                   serOut,
    output logic                   busy,
    output logic                   done
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [PORT_W-1:0]   port_q,  port_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [CNT_W-1:0]    left_q,  left_d;
    logic [1:0]          win_q,   win_d;
    logic [NREQ-1:0]     gnt_q,   gnt_d;
    logic [NREQ-1:0]     ack_q,   ack_d;
    logic [2:0]          bit_q,   bit_d;
    logic [3:0]          gap_q,   gap_d;
    logic [BYTE_W-1:0]   sh_q,    sh_d;
    logic                ser_q,   ser_d;
    logic                done_q,  done_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [1:0]          arb_idx;
    logic [BYTE_W-1:0]   cur_byte;

    rr_arbiter_4 u_arb (
        .req  (req),
        .last (win_q),
        .en   (state_q == IDLE),
        .gnt  (arb_gnt)
    );

    assign arb_idx  = onehot_idx(arb_gnt);
    assign cur_byte = req_data[{win_q, 3'b000} +: BYTE_W];

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        ser_d   = ser_q;
        ack_d   = '0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                ser_d = IDLE_LEVEL;
                if (arb_gnt != '0) begin
                    state_d = START;
                    win_d   = arb_idx;
                    gnt_d   = arb_gnt;
                    port_d  = req_port[{arb_idx, 1'b0} +: PORT_W];
                    cnt_d   = req_bytes[{arb_idx, 2'b00} +: CNT_W];
                    ser_d   = 1'b0;
                end
            end
            START: begin
                state_d = PORT;
                ser_d   = port_q[1];
                bit_d   = 3'd1;
            end
            PORT: begin
                if (bit_q != 3'd0) begin
                    ser_d = port_q[0];
                    bit_d = 3'd0;
                end else begin
                    state_d = COUNT;
                    ser_d   = cnt_q[3];
                    bit_d   = 3'd3;
                end
            end
            COUNT: begin
                if (bit_q != 3'd0) begin
                    ser_d = cnt_q[bit_q[1:0] - 2'd1];
                    bit_d = bit_q - 3'd1;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    ser_d   = IDLE_LEVEL;
                    gap_d   = GAP_LOAD;
                    done_d  = 1'b1;
                end else begin
                    state_d = DATA;
                    sh_d    = cur_byte;
                    ser_d   = cur_byte[BYTE_W-1];
                    bit_d   = 3'd7;
                    left_d  = cnt_q - 4'd1;
                    ack_d   = gnt_q;
                end
            end
            DATA: begin
                if (bit_q != 3'd0) begin
                    ser_d = sh_q[bit_q - 3'd1];
                    bit_d = bit_q - 3'd1;
                end else if (left_q != '0) begin
                    // next byte follows with no idle bit; requester swaps data on the ack
                    sh_d   = cur_byte;
                    ser_d  = cur_byte[BYTE_W-1];
                    bit_d  = 3'd7;
                    left_d = left_q - 4'd1;
                    ack_d  = gnt_q;
                end else begin
                    state_d = GAP;
                    ser_d   = IDLE_LEVEL;
                    gap_d   = GAP_LOAD;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                ser_d = IDLE_LEVEL;
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                ser_d   = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            port_q  <= '0;
            cnt_q   <= '0;
            left_q  <= '0;
            win_q   <= 2'd3;
            gnt_q   <= '0;
            ack_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sh_q    <= '0;
            ser_q   <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sh_q    <= sh_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign gnt      = gnt_q;
    assign byte_ack = ack_q;
    assign serOut   = ser_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Self-checking bench: frames observed on the line are compared against a bit-level frame model.
module tb_serial_tx_scheduler;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_port;
    logic [15:0] req_bytes;
    logic [31:0] req_data;
    logic [3:0]  gnt, byte_ack;
    logic        serOut, busy, done;

    logic [1:0]  cfg_port [4];
    logic [3:0]  cfg_n    [4];
    logic [7:0]  cur_byte [4];

    int n_checks = 0;
    int n_fail   = 0;
    int model_last = 3;

    int           obs_len, obs_wait, obs_gap_len, obs_done_cnt;
    logic [127:0] obs_vec;
    logic [3:0]   obs_gnt, obs_gnt_end;
    bit           obs_ack_bad, obs_gnt_bad, obs_gap_low, obs_timeout;
    int           obs_ack_pos [$];
    logic [7:0]   obs_ack_byte [$];

    always #5 clk = ~clk;

    assign req_port  = {cfg_port[3], cfg_port[2], cfg_port[1], cfg_port[0]};
    assign req_bytes = {cfg_n[3], cfg_n[2], cfg_n[1], cfg_n[0]};
    assign req_data  = {cur_byte[3], cur_byte[2], cur_byte[1], cur_byte[0]};

    serial_tx_scheduler #(.GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_port  (req_port),
        .req_bytes (req_bytes),
        .req_data  (req_data),
        .gnt       (gnt),
        .byte_ack  (byte_ack),
        .serOut    (serOut),
        .busy      (busy),
        .done      (done)
    );

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // cycle p of a frame holds bit p: start, port MSB first, count MSB first, bytes MSB first
    function automatic logic [127:0] exp_frame(input logic [1:0] port, input int n, input logic [7:0] bytes [$]);
        logic [127:0] v;
        logic [7:0]   b;
        v    = '0;
        v[1] = port[1];
        v[2] = port[0];
        for (int j = 0; j < 4; j++) v[3 + j] = 1'(n >> (3 - j));
        for (int k = 0; k < n; k++) begin
            b = (k < bytes.size()) ? bytes[k] : 8'h00;
            for (int j = 0; j < 8; j++) v[7 + 8 * k + j] = b[7 - j];
        end
        return v;
    endfunction

    function automatic int ack_pos_errors(input int n);
        int e;
        e = 0;
        for (int k = 0; k < obs_ack_pos.size(); k++) begin
            if (k >= n || obs_ack_pos[k] != 7 + 8 * k) e++;
        end
        return e;
    endfunction

    task automatic do_reset(input logic [3:0] r);
        reset = 1'b0;
        req   = r;
        repeat (2) @(posedge clk);
        #4 reset = 1'b1;
        model_last = 3;
    endtask

    // Records one frame (start through gap) and plays the requester side of the byte handshake.
    task automatic observe(input int chg_cycle, input logic [3:0] chg_val);
        int  cyc;
        bit  in_gap;
        bit  stop;
        int  idx;
        obs_len = 0; obs_vec = '0; obs_gap_len = 0; obs_done_cnt = 0; obs_wait = 0;
        obs_ack_bad = 0; obs_gnt_bad = 0; obs_gap_low = 0; obs_timeout = 0;
        obs_gnt = '0; obs_gnt_end = '1;
        obs_ack_pos.delete();
        obs_ack_byte.delete();
        do begin
            @(posedge clk); #1;
            obs_wait++;
        end while (!busy && obs_wait < 50);
        if (!busy) begin
            obs_timeout = 1;
            return;
        end
        obs_gnt = gnt;
        cyc = 0; in_gap = 0; stop = 0;
        while (!stop) begin
            if (!busy) begin
                obs_gnt_end = gnt;
                stop = 1;
            end else begin
                if (done) begin
                    obs_done_cnt++;
                    in_gap = 1;
                end
                if (gnt !== obs_gnt) obs_gnt_bad = 1;
                if (in_gap) begin
                    obs_gap_len++;
                    if (serOut !== 1'b1) obs_gap_low = 1;
                    if (byte_ack !== 4'b0) obs_ack_bad = 1;
                end else begin
                    if (cyc < 128) obs_vec[cyc] = serOut;
                    obs_len++;
                    if (byte_ack !== 4'b0) begin
                        if (byte_ack !== obs_gnt) obs_ack_bad = 1;
                        else begin
                            idx = 0;
                            for (int i = 0; i < 4; i++) if (byte_ack[i]) idx = i;
                            obs_ack_pos.push_back(cyc);
                            obs_ack_byte.push_back(cur_byte[idx]);
                            cur_byte[idx] = 8'($urandom);
                        end
                    end
                end
                if (cyc == chg_cycle) req = chg_val;
                cyc++;
                if (cyc > 250) begin
                    obs_timeout = 1;
                    stop = 1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (serOut !== 1'b1) begin n_fail++; $display("FAIL rst_serOut got=%b exp=1", serOut); end
        n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        n_checks++; if (byte_ack !== 4'b0) begin n_fail++; $display("FAIL rst_byte_ack got=%b exp=0000", byte_ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        #3 reset = 1'b1;
        model_last = 3;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || serOut !== 1'b1) begin n_fail++; $display("FAIL rst_idle got busy=%b ser=%b exp busy=0 ser=1", busy, serOut); end
    endtask

    task automatic test_basic();
        logic [7:0]   q [$];
        logic [127:0] e;
        cfg_port[0] = 2'd2; cfg_n[0] = 4'd1; cur_byte[0] = 8'hA5;
        q.push_back(8'hA5);
        e = exp_frame(2'd2, 1, q);
        req = 4'b0001;
        observe(0, 4'b0000);
        n_checks++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt got=%b exp=0001", obs_gnt); end
        n_checks++; if (obs_len !== 15) begin n_fail++; $display("FAIL basic_len got=%0d exp=15", obs_len); end
        n_checks++; if (obs_vec !== e) begin n_fail++; $display("FAIL basic_bits got=%h exp=%h", obs_vec, e); end
        n_checks++; if (obs_ack_pos.size() !== 1 || ack_pos_errors(1) !== 0) begin n_fail++; $display("FAIL basic_ack got=%0d acks exp=1 at cycle 7", obs_ack_pos.size()); end
        n_checks++; if (obs_gap_len !== GAP) begin n_fail++; $display("FAIL basic_gap got=%0d exp=%0d", obs_gap_len, GAP); end
        n_checks++; if (obs_done_cnt !== 1) begin n_fail++; $display("FAIL basic_done got=%0d exp=1", obs_done_cnt); end
        n_checks++; if ({obs_gnt_bad, obs_gap_low, obs_ack_bad, obs_timeout} !== 4'b0) begin n_fail++; $display("FAIL basic_flags got=%b exp=0000", {obs_gnt_bad, obs_gap_low, obs_ack_bad, obs_timeout}); end
        n_checks++; if (obs_gnt_end !== 4'b0) begin n_fail++; $display("FAIL basic_gnt_drop got=%b exp=0000", obs_gnt_end); end
        model_last = 0;
    endtask

    task automatic test_rr_order();
        int w;
        for (int i = 0; i < 4; i++) begin
            cfg_port[i] = 2'($urandom);
            cfg_n[i]    = 4'($urandom_range(0, 2));
            cur_byte[i] = 8'($urandom);
        end
        do_reset(4'b1111);
        for (int f = 0; f < 5; f++) begin
            w = rr_pick(4'b1111, model_last);
            observe((f == 4) ? 0 : -1, 4'b0000);
            n_checks++; if (obs_gnt !== 4'(1 << (f % 4))) begin n_fail++; $display("FAIL rr_order f=%0d got=%b exp=%b", f, obs_gnt, 4'(1 << (f % 4))); end
            n_checks++; if (obs_wait !== 1) begin n_fail++; $display("FAIL rr_spacing f=%0d got=%0d idle edges exp=1", f, obs_wait); end
            n_checks++; if (obs_vec !== exp_frame(cfg_port[w], int'(cfg_n[w]), obs_ack_byte) || obs_len !== 7 + 8 * int'(cfg_n[w])) begin n_fail++; $display("FAIL rr_frame f=%0d got len=%0d exp len=%0d", f, obs_len, 7 + 8 * int'(cfg_n[w])); end
            n_checks++; if (obs_gap_len !== GAP) begin n_fail++; $display("FAIL rr_gap f=%0d got=%0d exp=%0d", f, obs_gap_len, GAP); end
            model_last = w;
        end
    endtask

    task automatic test_zero_len();
        cfg_port[2] = 2'd3; cfg_n[2] = 4'd0;
        req = 4'b0100;
        observe(0, 4'b0000);
        n_checks++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL zero_gnt got=%b exp=0100", obs_gnt); end
        n_checks++; if (obs_len !== 7) begin n_fail++; $display("FAIL zero_len got=%0d exp=7", obs_len); end
        n_checks++; if (obs_vec[6:0] !== 7'b0000110) begin n_fail++; $display("FAIL zero_bits got=%b exp=0000110", obs_vec[6:0]); end
        n_checks++; if (obs_ack_pos.size() !== 0 || obs_ack_bad) begin n_fail++; $display("FAIL zero_ack got=%0d exp=0", obs_ack_pos.size()); end
        n_checks++; if (obs_gap_len !== GAP || obs_done_cnt !== 1 || obs_gnt_end !== 4'b0) begin n_fail++; $display("FAIL zero_gap got gap=%0d done=%0d gnt=%b exp gap=%0d done=1 gnt=0000", obs_gap_len, obs_done_cnt, obs_gnt_end, GAP); end
        model_last = 2;
    endtask

    task automatic test_max_len();
        cfg_port[1] = 2'($urandom); cfg_n[1] = 4'd15; cur_byte[1] = 8'($urandom);
        req = 4'b0010;
        observe(0, 4'b0000);
        n_checks++; if (obs_len !== 127) begin n_fail++; $display("FAIL max_len got=%0d exp=127", obs_len); end
        n_checks++; if (obs_ack_pos.size() !== 15) begin n_fail++; $display("FAIL max_ack_cnt got=%0d exp=15", obs_ack_pos.size()); end
        n_checks++; if (ack_pos_errors(15) !== 0 || obs_ack_bad) begin n_fail++; $display("FAIL max_ack_spacing got=%0d misplaced exp=0", ack_pos_errors(15)); end
        n_checks++; if (obs_vec !== exp_frame(cfg_port[1], 15, obs_ack_byte)) begin n_fail++; $display("FAIL max_bits got=%h exp=%h", obs_vec, exp_frame(cfg_port[1], 15, obs_ack_byte)); end
        n_checks++; if (obs_gap_len !== GAP || obs_gnt_bad) begin n_fail++; $display("FAIL max_gap got=%0d exp=%0d", obs_gap_len, GAP); end
        model_last = 1;
    endtask

    task automatic test_reset_midframe();
        int waited;
        cfg_port[3] = 2'd1; cfg_n[3] = 4'd3; cur_byte[3] = 8'h00;
        req = 4'b1000;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!busy && waited < 20);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (serOut !== 1'b0 || gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_pre got ser=%b gnt=%b exp ser=0 gnt=1000", serOut, gnt); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (serOut !== 1'b1) begin n_fail++; $display("FAIL mid_async_ser got=%b exp=1", serOut); end
        n_checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_gnt got gnt=%b busy=%b exp gnt=0000 busy=0", gnt, busy); end
        req = 4'b1010;
        cfg_port[1] = 2'd2; cfg_n[1] = 4'd1; cur_byte[1] = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || serOut !== 1'b1) begin n_fail++; $display("FAIL mid_held got busy=%b ser=%b exp busy=0 ser=1", busy, serOut); end
        #3 reset = 1'b1;
        model_last = 3;
        observe(0, 4'b0000);
        n_checks++; if (obs_wait !== 1) begin n_fail++; $display("FAIL mid_first_edge got=%0d exp=1", obs_wait); end
        n_checks++; if (obs_gnt !== 4'(1 << rr_pick(4'b1010, 3))) begin n_fail++; $display("FAIL mid_gnt got=%b exp=0010", obs_gnt); end
        n_checks++; if (obs_len !== 15 || obs_vec !== exp_frame(2'd2, 1, obs_ack_byte)) begin n_fail++; $display("FAIL mid_fresh got len=%0d exp len=15", obs_len); end
        model_last = 1;
    endtask

    task automatic test_drop_req();
        int busy_cnt;
        cfg_port[2] = 2'($urandom); cfg_n[2] = 4'd2; cur_byte[2] = 8'($urandom);
        req = 4'b0100;
        observe(10, 4'b0000);
        n_checks++; if (obs_len !== 23 || obs_ack_pos.size() !== 2) begin n_fail++; $display("FAIL drop_len got len=%0d acks=%0d exp len=23 acks=2", obs_len, obs_ack_pos.size()); end
        n_checks++; if (obs_vec !== exp_frame(cfg_port[2], 2, obs_ack_byte)) begin n_fail++; $display("FAIL drop_bits got=%h exp=%h", obs_vec, exp_frame(cfg_port[2], 2, obs_ack_byte)); end
        model_last = 2;
        busy_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        n_checks++; if (busy_cnt !== 0 || gnt !== 4'b0) begin n_fail++; $display("FAIL drop_no_regrant got busy=%0d gnt=%b exp busy=0 gnt=0000", busy_cnt, gnt); end
        req = 4'b0100;
        observe(0, 4'b0000);
        n_checks++; if (obs_gnt !== 4'b0100 || obs_wait !== 1) begin n_fail++; $display("FAIL drop_rereq got gnt=%b wait=%0d exp gnt=0100 wait=1", obs_gnt, obs_wait); end
        model_last = 2;
    endtask

    task automatic test_random();
        int         w;
        logic [3:0] r;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 4; i++) begin
                cfg_port[i] = 2'($urandom);
                cfg_n[i]    = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            end
            r = 4'($urandom_range(1, 15));
            req = r;
            w = rr_pick(r, model_last);
            observe(int'($urandom_range(0, 40)), 4'($urandom));
            n_checks++; if (obs_gnt !== 4'(1 << w) || obs_wait !== 1) begin n_fail++; $display("FAIL rand_gnt f=%0d got=%b wait=%0d exp=%b wait=1", f, obs_gnt, obs_wait, 4'(1 << w)); end
            n_checks++; if (obs_len !== 7 + 8 * int'(cfg_n[w]) || obs_ack_pos.size() !== int'(cfg_n[w]) || ack_pos_errors(int'(cfg_n[w])) !== 0) begin n_fail++; $display("FAIL rand_len f=%0d got len=%0d acks=%0d exp len=%0d acks=%0d", f, obs_len, obs_ack_pos.size(), 7 + 8 * int'(cfg_n[w]), cfg_n[w]); end
            n_checks++; if (obs_vec !== exp_frame(cfg_port[w], int'(cfg_n[w]), obs_ack_byte)) begin n_fail++; $display("FAIL rand_bits f=%0d got=%h exp=%h", f, obs_vec, exp_frame(cfg_port[w], int'(cfg_n[w]), obs_ack_byte)); end
            n_checks++; if (obs_gap_len !== GAP || obs_done_cnt !== 1 || obs_gnt_end !== 4'b0 || {obs_gnt_bad, obs_gap_low, obs_ack_bad, obs_timeout} !== 4'b0) begin n_fail++; $display("FAIL rand_gap f=%0d got gap=%0d done=%0d flags=%b exp gap=%0d done=1 flags=0000", f, obs_gap_len, obs_done_cnt, {obs_gnt_bad, obs_gap_low, obs_ack_bad, obs_timeout}, GAP); end
            model_last = w;
        end
        req = 4'b0;
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_port[i] = 2'd0;
            cfg_n[i]    = 4'd0;
            cur_byte[i] = 8'd0;
        end
        test_reset();
        test_basic();
        test_rr_order();
        test_zero_len();
        test_max_len();
        test_reset_midframe();
        test_drop_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
